// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared PC-unit types and default vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } pc_state_e;

   localparam logic [31:0] C_EXC_VEC = 32'h8000_0180;
   localparam int unsigned C_STEP    = 4;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
//  Module      : pc_ras
//  Description : Circular return-address stack; pushing when full drops oldest.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ras #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] top,
   output logic             empty
);

   localparam int unsigned C_PW = $clog2(RAS_DEPTH);
   localparam int unsigned C_CW = C_PW + 1;

   logic [WIDTH-1:0] r_mem [RAS_DEPTH];
   logic [C_PW-1:0]  r_ptr;
   logic [C_CW-1:0]  r_count;
   logic [C_PW-1:0]  w_top_idx;
   logic             w_do_pop;

   // r_ptr is the next free slot; the pointer wraps naturally at the depth.
   assign w_top_idx = r_ptr - C_PW'(1);
   assign top       = r_mem[w_top_idx];
   assign empty     = (r_count == '0);
   assign w_do_pop  = pop && !empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ptr   <= '0;
         r_count <= '0;
      end else if (push && w_do_pop) begin
         r_ptr   <= r_ptr;
      end else if (push) begin
         r_ptr <= r_ptr + C_PW'(1);
         if (r_count != C_CW'(RAS_DEPTH))
            r_count <= r_count + C_CW'(1);
      end else if (w_do_pop) begin
         r_ptr   <= r_ptr - C_PW'(1);
         r_count <= r_count - C_CW'(1);
      end
   end

   // Simultaneous push+pop replaces the top entry in place.
   always_ff @(posedge clock) begin
      if (push)
         r_mem[(push && w_do_pop) ? w_top_idx : r_ptr] <= data;
   end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
//  Module      : pc_unit
//  Description : Program counter with redirects, exception/eret and RAS.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
   import mips_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(C_EXC_VEC),
   parameter int unsigned      STEP      = C_STEP,
   parameter int unsigned      RAS_DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic             halt,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             call,
   input  logic             ret,
   input  logic [WIDTH-1:0] ret_target,
   input  logic             exception,
   input  logic             eret,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_next,
   output logic [WIDTH-1:0] epc_out,
   output logic             ras_empty,
   output logic             halted
);

   pc_state_e        r_state;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_epc;
   logic             r_halted;
   logic [WIDTH-1:0] w_seq;
   logic [WIDTH-1:0] w_ras_top;
   logic             w_ras_empty;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;

   assign w_seq    = r_pc + WIDTH'(STEP);
   assign w_accept = (r_state == ST_RUN) && !stall && !exception;
   // eret outranks call/ret, so the stack must stay untouched with it.
   assign w_push   = w_accept && !eret && call;
   assign w_pop    = w_accept && !eret && ret;

   always_comb begin
      pc_next = w_seq;
      if (exception)         pc_next = EXC_VEC;
      else if (eret)         pc_next = r_epc;
      else if (ret)          pc_next = w_ras_empty ? ret_target : w_ras_top;
      else if (jump)         pc_next = jump_target;
      else if (branch_taken) pc_next = branch_target;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_RUN;
         r_pc     <= RESET_VEC;
         r_epc    <= '0;
         r_halted <= 1'b0;
      end else if (r_state == ST_RUN) begin
         if (exception) begin
            r_pc  <= pc_next;
            r_epc <= r_pc;
         end else if (!stall) begin
            r_pc <= pc_next;
            if (halt) begin
               r_state  <= ST_HALTED;
               r_halted <= 1'b1;
            end
         end
      end
   end

   pc_ras #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clock (clock),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .data  (w_seq),
      .top   (w_ras_top),
      .empty (w_ras_empty)
   );

   assign pc_out    = r_pc;
   assign epc_out   = r_epc;
   assign ras_empty = w_ras_empty;
   assign halted    = r_halted;

endmodule

`default_nettype wire
